// File: rtl/divisor_arbitro_pkg.sv
// divisor_arbitro_pkg: shared states and default sizes for the divider arbiter
package divisor_arbitro_pkg;
  localparam int TAMANYO_DEF = 32;
  localparam int N_REQ_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, RELEASE, ZERO} estado_t;
endpackage

// File: rtl/divisor_arbitro_if.sv
// divisor_arbitro_if: requester and divider signals of the shared-divider arbiter
interface divisor_arbitro_if
  import divisor_arbitro_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF,
  parameter int N_REQ = N_REQ_DEF
);
  logic [N_REQ-1:0] Req;
  logic [N_REQ*tamanyo-1:0] Num_in;
  logic [N_REQ*tamanyo-1:0] Den_in;
  logic [N_REQ-1:0] Gnt;
  logic [N_REQ-1:0] Valid;
  logic [tamanyo-1:0] Coc;
  logic [tamanyo-1:0] Res;
  logic Busy;
  logic div_Start;
  logic [tamanyo-1:0] div_Num;
  logic [tamanyo-1:0] div_Den;
  logic [tamanyo-1:0] div_Coc;
  logic [tamanyo-1:0] div_Res;
  logic div_Done;
  modport slave (
    input Req, Num_in, Den_in, div_Coc, div_Res, div_Done,
    output Gnt, Valid, Coc, Res, Busy, div_Start, div_Num, div_Den
  );
  modport master (
    output Req, Num_in, Den_in, div_Coc, div_Res, div_Done,
    input Gnt, Valid, Coc, Res, Busy, div_Start, div_Num, div_Den
  );
endinterface

// File: rtl/divisor_arbitro_rr_arbiter.sv
// rr_arbiter: picks the first requester after ptr, wrapping modulo N_REQ
module rr_arbiter
  import divisor_arbitro_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int PW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    win,
  output logic             any
);
  logic [PW-1:0] c;
  // scanning from farthest to nearest lets the nearest candidate win
  always_comb begin
    win = ptr;
    any = |req;
    c = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      c = PW'((int'(ptr) + i) % N_REQ);
      if (req[c]) win = c;
    end
  end
endmodule

// File: rtl/divisor_arbitro.sv
// divisor_arbitro: round-robin sharing of one signed divider among N_REQ requesters
module divisor_arbitro
  import divisor_arbitro_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF,
  parameter int N_REQ = N_REQ_DEF
) (
  input logic CLK,
  input logic RST,
  divisor_arbitro_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  estado_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, owner_q, owner_d, win;
  logic any;
  logic [N_REQ-1:0] gnt_q, gnt_d, valid_q, valid_d;
  logic [tamanyo-1:0] coc_q, coc_d, res_q, res_d, num_q, num_d, den_q, den_d;
  logic [tamanyo-1:0] sel_num, sel_den;
  logic start_q, start_d;
  rr_arbiter #(.N_REQ(N_REQ)) u_rr (.req(bus.Req), .ptr(ptr_q), .win(win), .any(any));
  assign sel_num = bus.Num_in[int'(win)*tamanyo +: tamanyo];
  assign sel_den = bus.Den_in[int'(win)*tamanyo +: tamanyo];
  // the div_Done guard in IDLE discards a result left in flight across a reset
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    gnt_d = '0;
    valid_d = '0;
    coc_d = coc_q;
    res_d = res_q;
    start_d = start_q;
    num_d = num_q;
    den_d = den_q;
    case (state_q)
      IDLE: if (any && !bus.div_Done) begin
        owner_d = win;
        gnt_d = N_REQ'(1) << win;
        num_d = sel_num;
        den_d = sel_den;
        start_d = |sel_den;
        state_d = (|sel_den) ? RUN : ZERO;
      end
      RUN: if (bus.div_Done) begin
        coc_d = bus.div_Coc;
        res_d = bus.div_Res;
        valid_d = N_REQ'(1) << owner_q;
        start_d = 1'b0;
        state_d = RELEASE;
      end
      RELEASE: if (!bus.div_Done) begin
        ptr_d = owner_q;
        state_d = IDLE;
      end
      default: begin
        coc_d = '0;
        res_d = '0;
        valid_d = N_REQ'(1) << owner_q;
        ptr_d = owner_q;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ptr_q <= PW'(N_REQ - 1);
      owner_q <= '0;
      gnt_q <= '0;
      valid_q <= '0;
      coc_q <= '0;
      res_q <= '0;
      start_q <= 1'b0;
      num_q <= '0;
      den_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      gnt_q <= gnt_d;
      valid_q <= valid_d;
      coc_q <= coc_d;
      res_q <= res_d;
      start_q <= start_d;
      num_q <= num_d;
      den_q <= den_d;
    end
  end
  assign bus.Gnt = gnt_q;
  assign bus.Valid = valid_q;
  assign bus.Coc = coc_q;
  assign bus.Res = res_q;
  assign bus.Busy = state_q != IDLE;
  assign bus.div_Start = start_q;
  assign bus.div_Num = num_q;
  assign bus.div_Den = den_q;
endmodule

// File: tb/tb_divisor_arbitro.sv
// tb_divisor_arbitro: scoreboard bench with a behavioural divider beside the arbiter
module tb_divisor_arbitro;
  localparam int W = 32;
  localparam int N = 4;
  typedef struct {int idx; int coc; int res; bit zl;} exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  divisor_arbitro_if #(.tamanyo(W), .N_REQ(N)) bus();
  divisor_arbitro #(.tamanyo(W), .N_REQ(N)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  exp_t exp_q[$];
  int gnt_q[$];
  int total = 0, bad = 0, cyc = 0, n_valid = 0, stop_at = -1, start_cnt = 0, done_rises = 0;
  int lat = 3, hold = 0;
  bit [N-1:0] drop = '1;
  int gnt_cyc[N];
  bit done_prev = 1'b0;

  // divider: captures on Start, raises Done after lat edges, holds it hold edges past Start low
  logic m_busy = 1'b0, m_done = 1'b0;
  int m_cnt = 0, m_hc = 0;
  logic signed [W-1:0] m_a = '0, m_b = 1, m_coc = '0, m_res = '0;
  assign bus.div_Done = m_done;
  assign bus.div_Coc = m_coc;
  assign bus.div_Res = m_res;
  always @(posedge CLK) begin
    if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_coc <= m_a / m_b;
        m_res <= m_a % m_b;
        m_hc <= hold;
      end else m_cnt <= m_cnt - 1;
    end else if (m_done) begin
      if (!bus.div_Start) begin
        if (m_hc == 0) m_done <= 1'b0;
        else m_hc <= m_hc - 1;
      end
    end else if (bus.div_Start) begin
      m_busy <= 1'b1;
      m_cnt <= lat;
      m_a <= bus.div_Num;
      m_b <= bus.div_Den;
    end
  end

  function automatic int oh(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(string n, longint a, longint e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic issue(int i, int num, int den, int coc, int res);
    exp_t e;
    bus.Num_in[i*W +: W] = num;
    bus.Den_in[i*W +: W] = den;
    bus.Req[i] = 1'b1;
    e = '{i, coc, res, den == 0};
    exp_q.push_back(e);
    gnt_q.push_back(i);
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      if (bus.Req == '0 && !bus.Busy && exp_q.size() == 0 && !bus.div_Done) return;
    end
    total++;
    bad++;
    $display("FAIL timeout: pending=%0d busy=%0b", exp_q.size(), bus.Busy);
  endtask

  // monitor: grants and results against the queues
  initial begin
    int g, v;
    exp_t e;
    forever begin
      @(negedge CLK);
      cyc++;
      if (bus.div_Start) start_cnt++;
      if (bus.div_Done && !done_prev) done_rises++;
      if (!RST && bus.Gnt != '0) begin
        g = oh(bus.Gnt);
        v = gnt_q.size() != 0 ? gnt_q.pop_front() : -1;
        total++;
        if ($countones(bus.Gnt) != 1 || g != v || done_prev) begin
          bad++;
          $display("FAIL grant: got Gnt=%b done_before=%0b expected idx %0d", bus.Gnt, done_prev, v);
        end
        gnt_cyc[g] = cyc;
      end
      if (!RST && bus.Valid != '0) begin
        v = oh(bus.Valid);
        e = exp_q.size() != 0 ? exp_q.pop_front() : '{-1, 0, 0, 1'b0};
        total++;
        if ($countones(bus.Valid) != 1 || v != e.idx || $signed(bus.Coc) != e.coc ||
            $signed(bus.Res) != e.res || bus.div_Start || (e.zl && cyc - gnt_cyc[v] != 1)) begin
          bad++;
          $display("FAIL result: got Valid=%b Coc=%0d Res=%0d Start=%0b lat=%0d expected idx %0d Coc=%0d Res=%0d",
                   bus.Valid, $signed(bus.Coc), $signed(bus.Res), bus.div_Start, cyc - gnt_cyc[v],
                   e.idx, e.coc, e.res);
        end
        n_valid++;
        if (drop[v]) bus.Req[v] = 1'b0;
        if (n_valid == stop_at) bus.Req = '0;
      end
      done_prev = bus.div_Done;
    end
  end

  initial begin
    int s, r, v0;
    bus.Req = '0;
    bus.Num_in = '0;
    bus.Den_in = '0;
    repeat (2) @(negedge CLK);
    chk("rst_gnt", bus.Gnt, 0);
    chk("rst_valid", bus.Valid, 0);
    chk("rst_coc", bus.Coc, 0);
    chk("rst_res", bus.Res, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_start", bus.div_Start, 0);
    chk("rst_num", bus.div_Num, 0);
    chk("rst_den", bus.div_Den, 0);
    RST = 1'b0;
    @(negedge CLK);
    issue(0, 50, 2, 25, 0);
    @(negedge CLK);
    chk("start_after_grant", bus.div_Start, 1);
    wait_quiet();
    issue(2, -42, 8, -5, -2);
    wait_quiet();
    issue(3, -9, -6, 1, -3);
    wait_quiet();
    s = start_cnt;
    issue(1, 7, 0, 0, 0);
    wait_quiet();
    chk("zero_no_start", start_cnt - s, 0);
    chk("zero_coc_held", $signed(bus.Coc), 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    issue(0, 100, 7, 14, 2);
    issue(1, -100, 7, -14, -2);
    issue(2, 9, 0, 0, 0);
    issue(3, 100, -7, -14, 2);
    wait_quiet();
    chk("fair_last_coc", $signed(bus.Coc), -14);
    drop[0] = 1'b0;
    drop[3] = 1'b0;
    stop_at = n_valid + 4;
    issue(0, 30, 4, 7, 2);
    issue(3, -30, 4, -7, -2);
    issue(0, 30, 4, 7, 2);
    issue(3, -30, 4, -7, -2);
    wait_quiet();
    drop = '1;
    stop_at = -1;
    lat = 2;
    hold = 3;
    bus.Num_in[2*W +: W] = 100;
    bus.Den_in[2*W +: W] = 3;
    bus.Req[2] = 1'b1;
    gnt_q.push_back(2);
    for (int k = 0; k < 50 && !bus.div_Start; k++) @(negedge CLK);
    chk("abort_run_start", bus.div_Start, 1);
    RST = 1'b1;
    bus.Req[2] = 1'b0;
    r = done_rises;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", bus.Busy, 0);
    chk("abort_start", bus.div_Start, 0);
    for (int k = 0; k < 50 && !bus.div_Done; k++) @(negedge CLK);
    chk("abort_done_seen", done_rises - r, 1);
    chk("abort_busy_done", bus.Busy, 0);
    issue(1, 17, -4, -4, 1);
    wait_quiet();
    lat = 3;
    hold = 5;
    v0 = n_valid;
    issue(0, 20, 6, 3, 2);
    for (int k = 0; k < 50 && n_valid == v0; k++) @(negedge CLK);
    @(negedge CLK);
    for (int k = 0; k < 20 && bus.div_Done; k++) begin
      chk("release_busy", bus.Busy, 1);
      @(negedge CLK);
    end
    wait_quiet();
    chk("hold_one_valid", n_valid - v0, 1);
    chk("exp_left", exp_q.size(), 0);
    chk("gnt_left", gnt_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/divisor_arbitro.md
# divisor_arbitro

- Round-robin scheduler that shares one `Divisor_Algoritmico` signed divider between `N_REQ` requesters.
- Captures each winner's operands, sequences the divider's `Start`/`Done` handshake, and returns `Coc`/`Res` with a one-cycle `Valid` pulse to the owner.
- Zero denominators are resolved locally without occupying the divider.
- Sits between the requesting datapaths and the single divider instance at the top level.

## Interface

Parameters:
- `tamanyo`, 32, operand/result width (signed two's complement).
- `N_REQ`, 4, number of requesters (≥2).

Ports:
- `CLK`  in  1  clock; every register updates on its rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `Req`  in  N_REQ  per-requester request level.
- `Num_in`  in  N_REQ*tamanyo  numerators; slice i = `[i*tamanyo +: tamanyo]`.
- `Den_in`  in  N_REQ*tamanyo  denominators; same slicing.
- `Gnt`  out  N_REQ  one-hot, one-cycle pulse; operands of requester i were captured.
- `Valid`  out  N_REQ  one-hot, one-cycle pulse; `Coc`/`Res` belong to requester i.
- `Coc`  out  tamanyo  quotient, shared by all requesters, held until the next result.
- `Res`  out  tamanyo  remainder, shared by all requesters, held until the next result.
- `Busy`  out  1  state ≠ IDLE.
- `div_Start`  out  1  to divider `Start`.
- `div_Num`  out  tamanyo  to divider `Num`.
- `div_Den`  out  tamanyo  to divider `Den`.
- `div_Coc`  in  tamanyo  from divider `Coc`.
- `div_Res`  in  tamanyo  from divider `Res`.
- `div_Done`  in  1  from divider `Done`, level.

## Operation

**Reset.**
- Forces state IDLE and `ptr` = N_REQ-1, so requester 0 has first priority.
- Clears `Gnt`, `Valid`, `Coc`, `Res`, `div_Start`, `div_Num`, `div_Den`, and `owner`; `Busy` = 0.

**Round robin.**
- Candidate search order: `ptr`+1, `ptr`+2, … modulo N_REQ.
- The first candidate with `Req` high wins.
- `ptr` ← `owner` when the transaction completes.

**IDLE.**
- Grants only if some `Req` is high and `div_Done` = 0.
- The `div_Done` guard discards a stale result left in flight by a reset.
- On grant: `owner` ← winner, `Gnt[winner]` = 1, `div_Num`/`div_Den` ← winner's operands.
- Next state is ZERO if the captured denominator is 0, else RUN.

**RUN.**
- `div_Start` = 1 and operands are held stable.
- When `div_Done` = 1: `Coc` ← `div_Coc`, `Res` ← `div_Res`, `Valid[owner]` = 1, `div_Start` ← 0; go to RELEASE.

**RELEASE.**
- `div_Start` = 0; wait for `div_Done` = 0.
- Then `ptr` ← `owner` and go to IDLE.

**ZERO.**
- `Coc` ← 0, `Res` ← 0, `Valid[owner]` = 1, `ptr` ← `owner`; go to IDLE.
- `div_Start` never rises.

**Arithmetic.**
- The divider defines the results: quotient truncated toward zero, remainder takes the numerator's sign.
- The arbiter passes results through unmodified.

**Requester rule.**
- `Req[i]` must drop in the cycle `Valid[i]` is high.
- A `Req[i]` still sampled high afterwards counts as a new request.
- Operands only need to be stable in the cycle of the granting edge.

## Timing

- Edge e0 (IDLE grants): `Gnt[k]` and, if Den ≠ 0, `div_Start` are high during the following cycle.
- Divider path: `Valid[k]` is high the cycle after the first edge that samples `div_Done` = 1.
  - Latency from grant = divider latency + 1.
  - `div_Start` falls in that same cycle.
- Zero path: `Valid[k]` is high exactly one cycle after `Gnt[k]`. Next grant is possible at the following edge.
- Back-to-back: the next grant occurs at the first edge in IDLE with `div_Done` = 0. Minimum: 1 cycle after leaving RELEASE.
- Simultaneous requests: only one grant per edge; the others wait, with no loss and no reordering beyond round-robin.
- `Req` dropping mid-transaction does not abort it; `Valid` still pulses.
- `RST` mid-RUN:
  - `div_Start` is 0 the next cycle.
  - The pending result is dropped and no `Valid` is issued.
  - The next grant waits for `div_Done` = 0.
- Outputs are registered; there is no combinational path from `Req` to `Gnt`.

## Structure

Package `divisor_arbitro_pkg`:
- `estado_t` enum {IDLE, RUN, RELEASE, ZERO}.
- Default `tamanyo`, default `N_REQ`.

Sub-module `rr_arbiter`:
- Combinational.
- Inputs: `Req`, `ptr`. Outputs: winner index and an any-request flag.

The divider is instantiated beside this block at the top level, not inside it.

## Test plan

- Single request, `Req[0]`, Num=50, Den=2: `Gnt[0]` pulse, `div_Start` high until Done, then `Valid[0]` with Coc=25, Res=0; `div_Start` low in the `Valid` cycle.
- `Req[2]`, Num=-42, Den=8: Coc=-5, Res=-2 on `Valid[2]`. `Req[3]`, Num=-9, Den=-6: Coc=1, Res=-3 on `Valid[3]`.
- `Req[1]`, Num=7, Den=0: `Valid[1]` exactly 1 cycle after `Gnt[1]`, Coc=0, Res=0, `div_Start` never asserted.
- `Req` = 4'b1111 from reset, each requester dropping its `Req` on its own `Valid`: grant order 0, 1, 2, 3. Then with `Req[0]` and `Req[3]` held (re-requesting after `Valid`): grants alternate 0, 3, 0, 3.
- `RST` pulsed during RUN with `div_Done` rising 2 cycles later: no `Valid`, `Busy` = 0, and no grant until `div_Done` = 0. The next transaction 17/-4 returns Coc=-4, Res=1.
- Divider holding `div_Done` high 5 cycles after Start drops: arbiter stays in RELEASE with `Busy` = 1. Exactly one `Valid` pulse is issued.
